// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-ramp stage: default width and ramp FSM encoding.
package pwm_pkg;

  localparam int R_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter with a DIV prescaler; emits a 1-clk tick on the
// last cycle of every DIV-th period.
module pwm_period_tick #(
  parameter int R   = 8,
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic o_tick
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [R-1:0]  r_cnt;
  logic [DW-1:0] r_div;
  logic          w_wrap;

  assign w_wrap = (r_cnt == {R{1'b1}});
  assign o_tick = w_wrap && (r_div == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_div <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Accepts a target duty over valid/ready and slews duty toward it by STEP counts
// at PWM period boundaries, pulsing done when the target is reached.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int R    = R_DEFAULT,
  parameter int STEP = 16,
  parameter int DIV  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [R-1:0] target,
  input  logic         target_valid,
  output logic         target_ready,
  output logic [R-1:0] duty,
  output logic         busy,
  output logic         done
);

  localparam logic [R-1:0] STEP_V = R'(STEP);

  ramp_state_e  r_state, w_state_nxt;
  logic [R-1:0] r_duty, w_duty_nxt;
  logic [R-1:0] r_tgt, w_tgt_nxt;
  logic         r_done, w_done_nxt;
  logic         w_tick;
  logic [R-1:0] w_gap_up, w_gap_dn, w_stepped;

  pwm_period_tick #(
    .R   (R),
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .o_tick  (w_tick)
  );

  // Clamp on the remaining distance so the step can neither overshoot nor wrap.
  assign w_gap_up = r_tgt - r_duty;
  assign w_gap_dn = r_duty - r_tgt;

  always_comb begin
    w_stepped = r_tgt;
    if (r_duty < r_tgt) begin
      w_stepped = (w_gap_up <= STEP_V) ? r_tgt : r_duty + STEP_V;
    end else if (r_duty > r_tgt) begin
      w_stepped = (w_gap_dn <= STEP_V) ? r_tgt : r_duty - STEP_V;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_tgt_nxt   = r_tgt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (target_valid) begin
          w_tgt_nxt = target;
          if (target == r_duty) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (w_tick) begin
          w_duty_nxt = w_stepped;
          if (w_stepped == r_tgt) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_tgt   <= w_tgt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign duty         = r_duty;
  assign done         = r_done;
  assign busy         = (r_state == ST_RAMP);
  assign target_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: DIV=1 and DIV=2 instances share stimulus and are checked
// every cycle against an arithmetic model, plus literal duty sequences per scenario.
module tb_pwm_duty_ramp;

  localparam int R      = 8;
  localparam int STEP   = 16;
  localparam int PERIOD = 1 << R;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [R-1:0] target = '0;
  logic         target_valid = 1'b0;

  logic [R-1:0] duty1, duty2;
  logic         ready1, ready2, busy1, busy2, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_duty_ramp #(.R(R), .STEP(STEP), .DIV(1)) u_div1 (
    .clk(clk), .reset_n(reset_n), .target(target), .target_valid(target_valid),
    .target_ready(ready1), .duty(duty1), .busy(busy1), .done(done1)
  );

  pwm_duty_ramp #(.R(R), .STEP(STEP), .DIV(2)) u_div2 (
    .clk(clk), .reset_n(reset_n), .target(target), .target_valid(target_valid),
    .target_ready(ready2), .duty(duty2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k counts clock edges since reset release; a ramp update happens on
  // every edge where k is a multiple of DIV*period.
  int k;
  int m_duty [2];
  int m_tgt  [2];
  bit m_ramp [2];
  bit m_done [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = 0; m_tgt[i] = 0; m_ramp[i] = 0; m_done[i] = 0;
      end
    end else begin
      k++;
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (!m_ramp[i]) begin
          if (target_valid) begin
            m_tgt[i] = int'(target);
            if (m_tgt[i] == m_duty[i]) m_done[i] = 1;
            else m_ramp[i] = 1;
          end
        end else if (k % ((i + 1) * PERIOD) == 0) begin
          if (m_duty[i] < m_tgt[i])
            m_duty[i] = (m_duty[i] + STEP > m_tgt[i]) ? m_tgt[i] : m_duty[i] + STEP;
          else
            m_duty[i] = (m_duty[i] - STEP < m_tgt[i]) ? m_tgt[i] : m_duty[i] - STEP;
          if (m_duty[i] == m_tgt[i]) begin
            m_done[i] = 1;
            m_ramp[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("div1_duty",  32'(duty1),  32'(m_duty[0]));
      check("div1_busy",  32'(busy1),  32'(m_ramp[0]));
      check("div1_ready", 32'(ready1), 32'(!m_ramp[0]));
      check("div1_done",  32'(done1),  32'(m_done[0]));
      check("div2_duty",  32'(duty2),  32'(m_duty[1]));
      check("div2_busy",  32'(busy2),  32'(m_ramp[1]));
      check("div2_ready", 32'(ready2), 32'(!m_ramp[1]));
      check("div2_done",  32'(done2),  32'(m_done[1]));
    end
  end

  int q_val [$];
  int q_cyc [$];
  int n_done;

  task automatic send(input logic [R-1:0] val);
    @(negedge clk);
    target       = val;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  // Record every duty change of one instance until its done pulse or budget expiry.
  task automatic track(input int sel, input int budget);
    logic [R-1:0] prev, cur;
    bit           d;
    q_val.delete();
    q_cyc.delete();
    n_done = 0;
    prev = (sel == 0) ? duty1 : duty2;
    for (int c = 0; c < budget && n_done == 0; c++) begin
      @(negedge clk);
      cur = (sel == 0) ? duty1 : duty2;
      d   = (sel == 0) ? done1 : done2;
      if (cur != prev) begin
        q_val.push_back(int'(cur));
        q_cyc.push_back(k);
        prev = cur;
      end
      if (d) n_done++;
    end
    check($sformatf("inst%0d_done_seen", sel), 32'(n_done), 32'd1);
  endtask

  task automatic expect_seq(input string tag, input int gap, input int n,
                            input int e0, input int e1 = 0, input int e2 = 0, input int e3 = 0);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_nsteps"}, 32'(q_val.size()), 32'(n));
    for (int i = 0; i < n && i < q_val.size(); i++) begin
      check($sformatf("%s_step%0d", tag, i), 32'(q_val[i]), 32'(e[i]));
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i), 32'(q_cyc[i] - q_cyc[i-1]), 32'(gap));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_duty",  32'(duty1),  32'd0);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_done",  32'(done1),  32'd0);
    check("rst_ready", 32'(ready1), 32'd1);
    reset_n = 1'b1;

    // 1: soft start 0 -> 64
    send(8'd64);
    track(0, 5 * PERIOD);
    expect_seq("up64", PERIOD, 4, 16, 32, 48, 64);
    @(negedge clk);
    check("up64_busy_after", 32'(busy1), 32'd0);
    check("up64_done_once",  32'(done1), 32'd0);

    // 2: soft stop 64 -> 0
    send(8'd0);
    track(0, 5 * PERIOD);
    expect_seq("dn0", PERIOD, 4, 48, 32, 16, 0);
    check("dn0_ready", 32'(ready1), 32'd1);

    // 3: saturation near full scale
    send(8'd240);
    track(0, 16 * PERIOD);
    check("to240_duty", 32'(duty1), 32'd240);
    send(8'd255);
    track(0, 2 * PERIOD);
    expect_seq("to255", PERIOD, 1, 255);
    send(8'd250);
    track(0, 2 * PERIOD);
    expect_seq("to250", PERIOD, 1, 250);

    // 4: target_valid ignored while ramping
    send(8'd128);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      target       = 8'd0;
      target_valid = 1'b1;
      check("ramp_ready_low", 32'(ready1), 32'd0);
    end
    target_valid = 1'b0;
    track(0, 10 * PERIOD);
    check("ramp128_final", 32'(duty1), 32'd128);

    // 5: target equal to current duty
    send(8'd128);
    check("same_done", 32'(done1), 32'd1);
    check("same_busy", 32'(busy1), 32'd0);
    check("same_duty", 32'(duty1), 32'd128);

    // 6: reset in the middle of a ramp
    send(8'd0);
    for (int c = 0; c < 8 * PERIOD && duty1 != 8'd48; c++) @(negedge clk);
    check("mid_duty48", 32'(duty1), 32'd48);
    #2 reset_n = 1'b0;
    #1;
    check("async_duty1", 32'(duty1), 32'd0);
    check("async_busy1", 32'(busy1), 32'd0);
    check("async_duty2", 32'(duty2), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    check("rel_ready1", 32'(ready1), 32'd1);
    check("rel_ready2", 32'(ready2), 32'd1);

    // DIV=2 instance updates every two periods
    send(8'd32);
    track(1, 6 * PERIOD);
    expect_seq("div2", 2 * PERIOD, 2, 16, 32);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
